// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver: AXI4-Stream video sink with raster tracking,
// tuser/tlast framing checks, sticky error flags, per-frame checksum and
// frame counter.
// Optional build macro: RX_THROTTLE_EN (LFSR-driven tready backpressure).
//
// state   | meaning
// --------+--------------------------------------------------------
// HUNT    | waiting for a tuser beat; untagged beats are dropped
// RECV    | inside a frame, counting pixels toward the last one
module pixel_stream_receiver #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int X_BITS = 10,
  parameter int Y_BITS = 10
) (
  input  logic              in_stream_aclk,
  input  logic              axi_resetn,
  input  logic [31:0]       in_stream_tdata,
  input  logic [3:0]        in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  input  logic              err_clear,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [31:0]       frame_checksum,
  output logic              err_sof,
  output logic              err_eol,
  output logic              err_keep,
  output logic [X_BITS-1:0] x_pos,
  output logic [Y_BITS-1:0] y_pos
);

  localparam logic ST_HUNT = 1'b0;
  localparam logic ST_RECV = 1'b1;
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_SIZE - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(Y_SIZE - 1);

  logic              state_q, state_d;
  logic [X_BITS-1:0] x_q, x_d, pos_x;
  logic [Y_BITS-1:0] y_q, y_d, pos_y;
  logic [31:0]       sum_q, sum_d, sum_new;
  logic [31:0]       checksum_q, checksum_d;
  logic [15:0]       count_q, count_d;
  logic              done_q, done_d;
  logic              err_sof_q, err_sof_d;
  logic              err_eol_q, err_eol_d;
  logic              err_keep_q, err_keep_d;
  logic              tready_q, tready_d;
  logic              accept, at_eol;

  assign accept = in_stream_tvalid && tready_q;

`ifdef RX_THROTTLE_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) that gates tready
  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) lfsr_q <= 16'hACE1;
    else             lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign tready_d = (lfsr_q[1:0] != 2'b00);
`else
  assign tready_d = 1'b1;
`endif

  // Next-state: framing, raster position, checksum and error detection
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    sum_d      = sum_q;
    checksum_d = checksum_q;
    count_d    = count_q;
    done_d     = 1'b0;
    err_sof_d  = err_clear ? 1'b0 : err_sof_q;
    err_eol_d  = err_clear ? 1'b0 : err_eol_q;
    err_keep_d = err_clear ? 1'b0 : err_keep_q;
    pos_x      = x_q;
    pos_y      = y_q;
    sum_new    = sum_q;
    at_eol     = 1'b0;
    if (accept) begin
      if (in_stream_tkeep != 4'hF) err_keep_d = 1'b1;
      if (state_q == ST_RECV || in_stream_tuser) begin
        // A tuser beat always restarts at the origin, discarding any partial frame
        if (state_q == ST_RECV && in_stream_tuser) err_sof_d = 1'b1;
        pos_x   = in_stream_tuser ? '0 : x_q;
        pos_y   = in_stream_tuser ? '0 : y_q;
        sum_new = (in_stream_tuser ? 32'd0 : sum_q) + in_stream_tdata;
        at_eol  = (pos_x == X_LAST);
        if (in_stream_tlast != at_eol) err_eol_d = 1'b1;
        if (at_eol && pos_y == Y_LAST) begin
          done_d     = 1'b1;
          checksum_d = sum_new;
          count_d    = count_q + 16'd1;
          state_d    = ST_HUNT;
          x_d        = '0;
          y_d        = '0;
          sum_d      = 32'd0;
        end else begin
          state_d = ST_RECV;
          sum_d   = sum_new;
          if (at_eol) begin
            x_d = '0;
            y_d = pos_y + Y_BITS'(1);
          end else begin
            x_d = pos_x + X_BITS'(1);
            y_d = pos_y;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= ST_HUNT;
      x_q        <= '0;
      y_q        <= '0;
      sum_q      <= 32'd0;
      checksum_q <= 32'd0;
      count_q    <= 16'd0;
      done_q     <= 1'b0;
      err_sof_q  <= 1'b0;
      err_eol_q  <= 1'b0;
      err_keep_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sum_q      <= sum_d;
      checksum_q <= checksum_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_sof_q  <= err_sof_d;
      err_eol_q  <= err_eol_d;
      err_keep_q <= err_keep_d;
      tready_q   <= tready_d;
    end
  end

  assign in_stream_tready = tready_q;
  assign frame_done       = done_q;
  assign frame_count      = count_q;
  assign frame_checksum   = checksum_q;
  assign err_sof          = err_sof_q;
  assign err_eol          = err_eol_q;
  assign err_keep         = err_keep_q;
  assign x_pos            = x_q;
  assign y_pos            = y_q;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Scoreboard bench for pixel_stream_receiver with a 4x3 raster.
module tb_pixel_stream_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, err_clear;
  logic        tready, frame_done, err_sof, err_eol, err_keep;
  logic [15:0] frame_count;
  logic [31:0] frame_checksum;
  logic [1:0]  x_pos, y_pos;

  int passed = 0;
  int total  = 0;
  int low_cnt = 0;
  bit watch_ready = 0;

  typedef struct { logic [31:0] sum; logic [15:0] cnt; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pixel_stream_receiver #(.X_SIZE(4), .Y_SIZE(3), .X_BITS(2), .Y_BITS(2)) dut (
    .in_stream_aclk(clk), .axi_resetn(rst_n),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .err_clear(err_clear), .frame_done(frame_done), .frame_count(frame_count),
    .frame_checksum(frame_checksum), .err_sof(err_sof), .err_eol(err_eol),
    .err_keep(err_keep), .x_pos(x_pos), .y_pos(y_pos)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: every frame_done pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_frame_done: got pulse, expected none (count %0d)", frame_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_checksum", frame_checksum, e.sum);
        chk("frame_count", {16'd0, frame_count}, {16'd0, e.cnt});
      end
    end
    if (watch_ready && !tready) low_cnt++;
  end

  task automatic push(input logic [31:0] s, input logic [15:0] c);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [31:0] d, input logic u, input logic l,
                      input logic [3:0] k, input logic clr);
    logic acc;
    acc = 1'b0;
    tdata = d; tuser = u; tlast = l; tkeep = k; err_clear = clr; tvalid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = tready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) begin
      total++;
      $display("FAIL handshake_timeout: got tready low for 64 cycles, expected acceptance");
    end
    err_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // 12-beat frame of tdata=1..12; eol_alt moves the first tlast from beat 4 to beat 3
  task automatic frame(input bit eol_alt, input bit chk_pos);
    for (int i = 1; i <= 12; i++) begin
      logic l;
      l = (i == 8 || i == 12) || (eol_alt ? (i == 3) : (i == 4));
      beat(32'(i), i == 1, l, 4'hF, 1'b0);
      if (chk_pos && i == 5) begin
        chk("x_after_beat5", {30'd0, x_pos}, 32'd1);
        chk("y_after_beat5", {30'd0, y_pos}, 32'd1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"}, {31'd0, tready}, 32'd0);
    chk({tag, "_outs"}, {27'd0, frame_done, err_sof, err_eol, err_keep, 1'b0} | {30'd0, x_pos} | {30'd0, y_pos}, 32'd0);
    chk({tag, "_count"}, {16'd0, frame_count}, 32'd0);
    chk({tag, "_checksum"}, frame_checksum, 32'd0);
  endtask

  task automatic chk_errs(input string tag, input logic [2:0] req);
    chk(tag, {29'd0, err_sof, err_eol, err_keep}, {29'd0, req});
  endtask

  initial begin
    rst_n = 1'b0; tdata = '0; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b0;
    tvalid = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
`ifndef RX_THROTTLE_EN
    chk("tready_after_reset", {31'd0, tready}, 32'd1);
`endif
    watch_ready = 1;

    // Clean frame
    push(32'd78, 16'd1);
    frame(1'b0, 1'b1);
    chk_errs("errs_clean", 3'b000);
    chk("pos_after_frame", {28'd0, x_pos, y_pos}, 32'd0);
    idle(3);
    chk("checksum_hold", frame_checksum, 32'd78);

    // Misplaced tlast, then clear
    push(32'd78, 16'd2);
    frame(1'b1, 1'b0);
    chk_errs("errs_eol", 3'b010);
    idle(1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk_errs("errs_cleared", 3'b000);

    // Untagged beats in HUNT are dropped
    beat(32'd100, 1'b0, 1'b0, 4'hF, 1'b0);
    beat(32'd200, 1'b0, 1'b0, 4'hF, 1'b0);
    beat(32'd300, 1'b0, 1'b1, 4'hF, 1'b0);
    chk("hunt_x_stays_0", {28'd0, x_pos, y_pos}, 32'd0);
    push(32'd78, 16'd3);
    frame(1'b0, 1'b0);
    chk_errs("errs_hunt", 3'b000);

    // tuser on beat 6 restarts the frame
    for (int i = 1; i <= 5; i++) beat(32'(i * 1000), i == 1, i == 4, 4'hF, 1'b0);
    push(32'd78, 16'd4);
    frame(1'b0, 1'b0);
    chk_errs("errs_sof", 3'b100);
    idle(1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;

    // Back-to-back frames, then reset mid-way through a third
    push(32'd78, 16'd5);
    push(32'd78, 16'd6);
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) beat(32'(i), i == 1, i == 4, 4'hF, 1'b0);
    chk("count_before_reset", {16'd0, frame_count}, 32'd6);
    watch_ready = 0;
    tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    watch_ready = 1;
    push(32'd78, 16'd1);
    frame(1'b0, 1'b0);

    // tkeep error wins over a simultaneous err_clear; checksum wraps at 32 bits
    push(32'h4000_0000, 16'd2);
    for (int i = 1; i <= 12; i++)
      beat(32'h3000_0000, i == 1, (i % 4) == 0, (i == 2) ? 4'h7 : 4'hF, i == 2);
    chk_errs("errs_keep", 3'b001);
    idle(4);

    chk("pending_frames", exp_q.size(), 32'd0);
`ifdef RX_THROTTLE_EN
    chk("tready_gaps_seen", {31'd0, low_cnt > 0}, 32'd1);
`else
    chk("tready_low_cycles", low_cnt, 32'd0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_stream_receiver.md
Name: pixel_stream_receiver

Overview:
AXI4-Stream video sink, the consuming end of the pixel generator's out_stream interface. It drives tready and accepts 32-bit pixel beats. It tracks x/y raster position, checks the tuser (start-of-frame) and tlast (end-of-line) framing, and reports sticky framing errors, a per-frame checksum and a frame counter. It is used in simulation benches and on-chip as a loopback/self-check sink for the video path.

Parameters:
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame
X_BITS, 10, width of x counter; must satisfy 2^X_BITS >= X_SIZE
Y_BITS, 10, width of y counter; must satisfy 2^Y_BITS >= Y_SIZE

Ports:
in_stream_aclk  input  1  single clock for all logic
axi_resetn  input  1  asynchronous active-low reset
in_stream_tdata  input  32  pixel data
in_stream_tkeep  input  4  byte enables; must be 4'hF
in_stream_tlast  input  1  end of line
in_stream_tuser  input  1  start of frame (first pixel of the frame)
in_stream_tvalid  input  1  beat valid
in_stream_tready  output  1  sink ready
err_clear  input  1  synchronous clear of the sticky error flags
frame_done  output  1  one-cycle pulse after the final pixel of a frame is accepted
frame_count  output  16  completed frames; wraps 0xFFFF->0
frame_checksum  output  32  checksum of the last completed frame
err_sof  output  1  sticky: tuser seen mid-frame
err_eol  output  1  sticky: tlast disagrees with position
err_keep  output  1  sticky: tkeep != 4'hF on an accepted beat
x_pos  output  X_BITS  next expected x
y_pos  output  Y_BITS  next expected y

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; state HUNT; internal sum 0. Reset asserted mid-frame discards the partial frame with no frame_done.
- Registered tready: goes 1 on the first clock edge after axi_resetn deasserts and then stays 1, except as modified by the optional feature.
- Accept = tvalid && tready. No state changes on non-accepted cycles.
- HUNT: an accepted beat without tuser is dropped, with no error and no counters changed. An accepted beat with tuser:
  - sum <= tdata
  - x <= 1, y <= 0 (wraps to x=0, y=1 if X_SIZE==1)
  - go to RECV
  - check tlast on this beat as for any pixel.
- RECV, accepted beat at position (x,y):
  - tuser=1: set err_sof and restart the frame exactly as in HUNT. The old frame is discarded with no frame_done.
  - tuser=0:
    - sum <= sum + tdata (32-bit wrap)
    - x <= x+1
    - at x==X_SIZE-1: x <= 0, y <= y+1
  - Line length is set by the counter only. tlast is checked, never used for resync.
- tlast check (every accepted framed beat): tlast != (x==X_SIZE-1) sets err_eol.
- tkeep check: any accepted beat (HUNT or RECV) with tkeep != 4'hF sets err_keep.
- Frame end: a beat accepted at x==X_SIZE-1, y==Y_SIZE-1 causes, on the next cycle:
  - frame_done=1 for one cycle
  - frame_checksum = final sum including that beat
  - frame_count+1
  - state HUNT, x_pos=0, y_pos=0
- Back-to-back frames: a tuser beat on the cycle after the final beat is accepted normally from HUNT. Zero bubble.
- err_clear: clears all sticky flags. If a new error is detected in the same cycle, the error wins (flag stays 1).
- frame_checksum and frame_count hold between frames.

Optional Feature:
RX_THROTTLE_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle. tready = (lfsr[1:0] != 2'b00), giving about 75% duty to exercise source backpressure. Framing and checksum are unaffected.
- Undefined: no LFSR; tready is constant 1 after reset.

Test Plan:
- Bench uses X_SIZE=4, Y_SIZE=3, tvalid=1. Frame of tdata=1..12, tuser on beat 1, tlast on beats 4, 8, 12 -> frame_done pulses once, one cycle after beat 12; frame_checksum=78; frame_count=1; all error flags 0.
- Same frame with tlast on beat 3 instead of beat 4 -> err_eol=1. Frame still completes after 12 beats, checksum=78. Assert err_clear -> err_eol=0 the next cycle.
- Three beats without tuser, then a valid frame -> first 3 beats ignored; checksum of the frame only; frame_count=1; no errors.
- tuser reasserted on beat 6 of a frame, then 12 beats of tdata=1..12 -> err_sof=1; exactly one frame_done, at the end of the restarted frame, with checksum 78.
- Two frames back-to-back with no bubble, then reset asserted mid-way through a third -> frame_count=2. After reset all outputs are 0; a following frame gives frame_count=1.
- Beat with tkeep=4'h7 -> err_keep=1. With RX_THROTTLE_EN defined, a 12-beat frame held valid under tready gaps -> checksum=78 and tready is low on some cycles.
